truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner_pkg.sv | 16 +
 rtl/truth_table_scanner_settle_timer.sv | 39 +++
 rtl/truth_table_scanner.sv | 140 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizes for the truth table scanner.
// Holds the FSM state enum and vector/index/error-count widths.
package truth_table_scanner_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int ERR_W       = 5;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CAPTURE,
    DONE
  } state_e;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle timer: counts enabled cycles while a vector is held.
// Ports: clk, reset (sync, high), clear, enable in; expired out.
module settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // expired is high during the SETTLE-th enabled cycle, so the
  // owner can leave the hold state on that same edge.
  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks a 4-input function through all 16 vectors and grades it.
// In: clk, reset, start, abort, F. Out: A..D, busy, done, table_o, err_count, pass.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h0DD0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             F,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             busy,
  output logic             done,
  output logic [15:0]      table_o,
  output logic [ERR_W-1:0] err_count,
  output logic             pass
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VECTORS);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       vec_q, vec_d;
  logic [NUM_VECTORS-1:0] table_q, table_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic                   pass_q, pass_d;
  logic                   tmr_clear;
  logic                   tmr_en;
  logic                   tmr_exp;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    table_d   = table_q;
    err_d     = err_q;
    pass_d    = pass_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = APPLY;
          idx_d     = '0;
          table_d   = '0;
          err_d     = '0;
          pass_d    = 1'b0;
          tmr_clear = 1'b1;
        end
      end
      APPLY: begin
        if (abort) begin
          state_d   = IDLE;
          pass_d    = 1'b0;
          tmr_clear = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tmr_exp) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        tmr_clear = 1'b1;
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          table_d[idx_q] = F;
          if ((F != EXPECTED[idx_q]) && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            // Graded here so pass is valid alongside done.
            pass_d  = (err_d == '0);
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = APPLY;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Stimulus follows the next state so A..D change on the same
    // edge that enters APPLY and drop to zero outside the scan.
    if ((state_d == APPLY) || (state_d == CAPTURE)) begin
      vec_d = idx_d;
    end else begin
      vec_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      table_q <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign {A, B, C, D} = vec_q;
  assign busy      = (state_q == APPLY) || (state_q == CAPTURE);
  assign done      = (state_q == DONE);
  assign table_o   = table_q;
  assign err_count = err_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner.
// Expected results come from the function table under test.
module tb_truth_table_scanner;

  localparam int S0   = 2;
  localparam int LAT  = 16 * (S0 + 1) + 1;
  localparam int LAT1 = 16 * (1 + 1) + 1;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  err;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, abort, f;
  logic        a, b, c, d, busy, done, pass;
  logic [15:0] tbl;
  logic [4:0]  err;
  logic        start1, abort1, f1;
  logic        a1, b1, c1, d1, busy1, done1, pass1;
  logic [15:0] tbl1;
  logic [4:0]  err1;

  logic [15:0] golden = 16'h0DD0;
  logic [15:0] fut;
  exp_t        sbq[$];
  time         acc_t;
  logic        scanning;
  int          total = 0;
  int          bad = 0;
  exp_t        e_m;
  longint      n_m;

  assign f  = fut[{a, b, c, d}];
  assign f1 = golden[{a1, b1, c1, d1}];

  always #5 clk = ~clk;

  truth_table_scanner #(.SETTLE(S0), .EXPECTED(16'h0DD0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .F(f),
    .A(a), .B(b), .C(c), .D(d), .busy(busy), .done(done),
    .table_o(tbl), .err_count(err), .pass(pass)
  );

  truth_table_scanner #(.SETTLE(1), .EXPECTED(16'h0DD0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .F(f1),
    .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
    .table_o(tbl1), .err_count(err1), .pass(pass1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: vector order while busy, results when done.
  always @(negedge clk) begin
    if (!reset) begin
      n_m = scanning ? longint'(($time - acc_t - 5) / 10) + 1 : 0;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e_m = sbq.pop_front();
          chk("latency", n_m, LAT);
          chk("table", tbl, e_m.tbl);
          chk("err_count", err, e_m.err);
          chk("pass", pass, e_m.pass);
        end
      end else if (scanning && n_m == LAT && sbq.size() != 0) begin
        chk("done_missing", done, 1);
        void'(sbq.pop_front());
      end
      if (scanning && n_m >= 1 && n_m <= LAT - 1) begin
        chk("busy_in_scan", busy, 1);
        chk("vector", {a, b, c, d}, (n_m - 1) / (S0 + 1));
      end
    end
  end

  task automatic begin_scan(input logic [15:0] fn);
    @(posedge clk);
    #2;
    fut   = fn;
    start = 1'b1;
    @(posedge clk);
    acc_t    = $time;
    scanning = 1'b1;
    #2 start = 1'b0;
  endtask

  function automatic exp_t model(input logic [15:0] fn);
    exp_t e;
    e.tbl  = fn;
    e.err  = 5'($countones(fn ^ golden));
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic run_scan(input logic [15:0] fn);
    @(posedge clk);
    #2;
    fut   = fn;
    start = 1'b1;
    @(posedge clk);
    acc_t    = $time;
    sbq.push_back(model(fn));
    scanning = 1'b1;
    #2 start = 1'b0;
    for (int k = 0; k < LAT + 20 && sbq.size() != 0; k++) @(posedge clk);
    if (sbq.size() != 0) begin
      chk("scan_timeout", sbq.size(), 0);
      sbq.delete();
    end
    scanning = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rnd;
    int          nd;
    int          dc;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    fut = golden; scanning = 1'b0;
    repeat (3) @(posedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec", {a, b, c, d}, 0);
    chk("rst_table", tbl, 0);
    chk("rst_err", err, 0);
    chk("rst_pass", pass, 0);
    @(posedge clk);
    #2 start = 1'b0; reset = 1'b0;

    run_scan(golden);
    repeat (4) @(negedge clk);
    chk("hold_pass", pass, 1);
    chk("hold_table", tbl, golden);
    chk("hold_err", err, 0);
    chk("idle_busy", busy, 0);
    chk("idle_vec", {a, b, c, d}, 0);

    run_scan(16'h0000);
    run_scan(16'hFFFF);
    for (int i = 0; i < 6; i++) begin
      rnd = 16'($urandom);
      if (i == 0) rnd = golden ^ 16'h8001;
      run_scan(rnd);
    end

    @(posedge clk);
    #2 start = 1'b1; abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sa_busy", busy, 0);
      chk("sa_vec", {a, b, c, d}, 0);
    end
    @(posedge clk);
    #2 start = 1'b0; abort = 1'b0;

    rnd = 16'($urandom);
    begin_scan(rnd);
    repeat (21) @(posedge clk);
    #2 abort = 1'b1; scanning = 1'b0;
    @(posedge clk);
    #2 abort = 1'b0;
    @(negedge clk);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_table", tbl, rnd & 16'h007F);
    chk("ab_err", err, $countones((rnd ^ golden) & 16'h007F));
    chk("ab_pass", pass, 0);
    chk("ab_vec", {a, b, c, d}, 0);
    repeat (6) @(negedge clk);

    rnd = 16'($urandom);
    @(posedge clk);
    #2; fut = rnd; start = 1'b1;
    @(posedge clk);
    acc_t = $time; scanning = 1'b1;
    sbq.push_back(model(rnd));
    #2 start = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset = 1'b1; scanning = 1'b0; sbq.delete();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_vec", {a, b, c, d}, 0);
      chk("mr_table", tbl, 0);
      chk("mr_err", err, 0);
      chk("mr_pass", pass, 0);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    run_scan(16'($urandom));

    nd = 0; dc = 0;
    @(posedge clk);
    #2 start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done1) begin
        nd++;
        dc = k;
        chk("s1_table", tbl1, golden);
        chk("s1_err", err1, 0);
        chk("s1_pass", pass1, 1);
      end
    end
    start1 = 1'b0;
    chk("s1_done_count", nd, 1);
    chk("s1_done_cycle", dc, LAT1);
    @(posedge clk);
    #2 abort1 = 1'b1;
    @(posedge clk);
    #2 abort1 = 1'b0;
    @(negedge clk);
    chk("s1_idle", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
